// File: rtl/cordic_ci_sequencer.sv
// Custom-instruction front end for an iterative cosine CORDIC core.
// Latency: start at cycle T -> core_load T+1, core_en T+2..T+1+ITERS, done T+3+ITERS; each clk_en-low cycle adds one.
// Backpressure: none; clk_en low freezes everything, and a start while busy is dropped and flagged in overlap_err.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clk_en            global stall; low holds all state and masks strobes
//   start, dataa      request pulse with its angle operand
//   done, result      one-cycle completion pulse and IEEE-754 single result
//   busy, overlap_err not-idle indicator, sticky "start while busy" flag
//   core_load/angle   load strobe and latched angle towards the CORDIC core
//   core_en/iter      iteration step enable and iteration index
//   core_x            unsigned fixed-point X result from the core
module cordic_ci_sequencer #(
  parameter int FRACS  = 22,
  parameter int INTS   = 1,
  parameter int WIDTH  = INTS + FRACS,
  parameter int ITERS  = 16,
  parameter int ITER_W = $clog2(ITERS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [31:0]       dataa,
  output logic              done,
  output logic [31:0]       result,
  output logic              busy,
  output logic              overlap_err,
  output logic              core_load,
  output logic [31:0]       core_angle,
  output logic              core_en,
  output logic [ITER_W-1:0] core_iter,
  input  logic [WIDTH-1:0]  core_x
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CONV,
    S_DONE
  } state_t;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  // Bits below the integer bit: the implied leading one followed by the
  // fraction that becomes the mantissa.
  localparam int LOW_W = WIDTH - 1;

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [31:0]         angle_q, angle_d;
  logic [31:0]         result_q, result_d;
  logic                ovl_q, ovl_d;

  logic                load_c;
  logic                en_c;
  logic                done_c;

  // Float conversion. core_x lies in [0.5, 1.0]: the integer bit set means
  // exactly 1.0, otherwise the value is 0.1xxx binary, i.e. exponent 126
  // with core_x[WIDTH-2] as the implied one. Appending 24 zeros and keeping
  // the top 24 bits gives {implied one, 23-bit mantissa}, which handles
  // zero padding for narrow fractions and truncation for wide ones; the
  // cast then drops the implied one.
  logic [LOW_W+23:0]   frac_ext;
  logic [22:0]         mant;
  logic [31:0]         conv_f;

  assign frac_ext = {core_x[WIDTH-2:0], 24'd0};
  assign mant     = 23'(frac_ext >> LOW_W);
  assign conv_f   = core_x[WIDTH-1] ? 32'h3F80_0000 : {1'b0, 8'd126, mant};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      angle_q  <= '0;
      result_q <= '0;
      ovl_q    <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      angle_q  <= angle_d;
      result_q <= result_d;
      ovl_q    <= ovl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    angle_d  = angle_q;
    result_d = result_q;
    ovl_d    = ovl_q;
    load_c   = 1'b0;
    en_c     = 1'b0;
    done_c   = 1'b0;

    // DONE counts as busy, so a back-to-back start there is also dropped.
    if (start && (state_q != S_IDLE)) begin
      ovl_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          angle_d = dataa;
          ovl_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_c  = 1'b1;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        en_c = 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_CONV;
        end else begin
          cnt_d = cnt_q + ITER_W'(1);
        end
      end
      S_CONV: begin
        result_d = conv_f;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are masked while stalled so the core never sees a repeated
  // load or step during a frozen cycle.
  assign core_load   = load_c & clk_en;
  assign core_en     = en_c & clk_en;
  assign done        = done_c & clk_en;
  assign busy        = (state_q != S_IDLE);
  assign overlap_err = ovl_q;
  assign core_angle  = angle_q;
  assign core_iter   = cnt_q;
  assign result      = result_q;

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
module tb_cordic_ci_sequencer;

  localparam int FRACS  = 22;
  localparam int INTS   = 1;
  localparam int WIDTH  = INTS + FRACS;
  localparam int ITERS  = 16;
  localparam int ITER_W = $clog2(ITERS);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clk_en;
  logic              start;
  logic [31:0]       dataa;
  logic              done;
  logic [31:0]       result;
  logic              busy;
  logic              overlap_err;
  logic              core_load;
  logic [31:0]       core_angle;
  logic              core_en;
  logic [ITER_W-1:0] core_iter;
  logic [WIDTH-1:0]  core_x;

  cordic_ci_sequencer #(
    .FRACS(FRACS), .INTS(INTS), .ITERS(ITERS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa),
    .done(done), .result(result), .busy(busy), .overlap_err(overlap_err),
    .core_load(core_load), .core_angle(core_angle), .core_en(core_en),
    .core_iter(core_iter), .core_x(core_x)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] ang;
    int          t_start;
    int          done_cyc;
  } exp_t;

  exp_t q[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int exp_iter = 0;
  int en_cnt   = 0;
  int done_cnt = 0;

  wire [40:0] out_vec = {done, busy, overlap_err, core_load, core_en, core_iter, result};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference float for an X value below/at 1.0 in Q1.22.
  function automatic logic [31:0] ref_float(input logic [22:0] x);
    logic [20:0] f;
    if (x[22]) return 32'h3F80_0000;
    f = x[20:0];
    return {1'b0, 8'd126, f, 2'b00};
  endfunction

  // Monitor: load/step/done sequencing against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_load) begin
        if (q.size() == 0) begin
          chk("load_unexpected", core_load, 0);
        end else begin
          chk("load_cycle", cyc, q[0].t_start + 1);
          chk("core_angle", core_angle, q[0].ang);
        end
        exp_iter = 0;
        en_cnt   = 0;
      end
      if (core_en) begin
        chk("core_iter", core_iter, exp_iter);
        exp_iter++;
        en_cnt++;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", cyc, e.done_cyc);
          chk("en_count", en_cnt, ITERS);
          done_cnt++;
        end
      end
    end
  end

  // Assumes we are just after a rising edge.
  task automatic drive_start(input logic [31:0] ang, input logic [22:0] x,
                             input int extra, output int t);
    exp_t e;
    start  = 1'b1;
    dataa  = ang;
    core_x = x;
    t      = cyc;
    e.res      = ref_float(x);
    e.ang      = ang;
    e.t_start  = t;
    e.done_cyc = t + ITERS + 3 + extra;
    q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ang, input logic [22:0] x,
                       input int extra, output int t);
    @(posedge clk); #1;
    drive_start(ang, x, extra, t);
    @(posedge clk); #1;
    start = 1'b0;
    dataa = 32'hDEAD_BEEF;
  endtask

  task automatic advance_to(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_in_time", (n < 300), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [ITER_W-1:0] held;

    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    dataa   = '0;
    core_x  = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec, 0);
    chk("reset_angle", core_angle, 0);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_outputs", out_vec, 0);
    chk("idle_angle", core_angle, 0);
    chk("idle_busy", busy, 0);

    // Basic operation: saturated 1.0
    issue(32'h3F00_0000, 23'h400000, 0, t);
    @(negedge clk);
    chk("busy_in_load", busy, 1);
    wait_idle();
    chk("result_hold", result, 32'h3F80_0000);

    // Fractional values
    issue(32'h3E80_0000, 23'h3A0000, 0, t);
    wait_idle();
    chk("frac_090625", result, 32'h3F68_0000);
    issue(32'h3F40_0000, 23'h200000, 0, t);
    wait_idle();
    chk("frac_05", result, 32'h3F00_0000);
    issue(32'h3DCC_CCCD, 23'h3ABCDE, 0, t);
    wait_idle();

    // Stall for 4 cycles in the middle of ITER
    issue(32'h1234_5678, 23'h2ABCDE, 4, t);
    advance_to(t + 6);
    clk_en = 1'b0;
    held   = core_iter;
    repeat (4) begin
      @(negedge clk);
      chk("stall_en", core_en, 0);
      chk("stall_iter", core_iter, held);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    wait_idle();

    // Overlapping start is dropped and flagged
    issue(32'hCAFE_0001, 23'h311111, 0, t);
    advance_to(t + 5);
    start = 1'b1;
    dataa = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("overlap_set", overlap_err, 1);
    wait_idle();
    advance_to(t + 25);
    begin
      int t2;
      drive_start(32'hCAFE_0002, 23'h255555, 0, t2);
    end
    @(negedge clk);
    chk("overlap_sticky", overlap_err, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("overlap_cleared", overlap_err, 0);
    wait_idle();

    // Abort by reset mid-operation
    issue(32'h7777_0000, 23'h3FFFFF, 0, t);
    advance_to(t + 8);
    reset_n = 1'b0;
    q.delete();
    exp_iter = 0;
    en_cnt   = 0;
    @(negedge clk);
    chk("abort_outputs", out_vec, 0);
    chk("abort_angle", core_angle, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("abort_idle", busy, 0);
    issue(32'h4000_0000, 23'h234567, 0, t);
    wait_idle();

    chk("done_count", done_cnt, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
